run_dump_controller: RTL and testbench

- Synthesizable run/observe controller for KGPminiRISC.
- Holds the CPU in reset, then releases it.
- Runs the CPU until it halts or a programmable cycle budget expires, then freezes it.
- Streams a selected data-memory window and a selected register subset out over a valid/ready port. This replaces fixed-delay, hard-coded-address result inspection with a parametrised, hardware-driven dump usable both in simulation and on board.

---
 rtl/run_dump_controller_if.sv | 23 ++
 rtl/run_dump_controller.sv | 207 ++++++++++++++++++++
 tb/tb_run_dump_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/run_dump_controller_if.sv
// Dump stream port: one word per valid/ready handshake, tagged with its
// source (memory or register) and address.
interface run_dump_controller_if #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 10
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_is_reg;
    logic [MEM_AW-1:0] out_addr;
    logic              out_last;

    modport master (
        output out_valid, out_data, out_is_reg, out_addr, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_is_reg, out_addr, out_last,
        output out_ready
    );
endinterface

// File: rtl/run_dump_controller.sv
// Run/observe controller: resets the CPU, runs it until halt or cycle budget,
// freezes it, then streams a memory window and a register subset out.
module run_dump_controller #(
    parameter int DATA_W     = 32,
    parameter int MEM_AW     = 10,
    parameter int REG_AW     = 5,
    parameter int CYC_W      = 24,
    parameter int RST_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CYC_W-1:0]       timeout_cycles,
    input  logic [MEM_AW-1:0]      mem_base,
    input  logic [MEM_AW:0]        mem_words,
    input  logic [2**REG_AW-1:0]   reg_mask,
    input  logic                   halt,
    output logic                   cpu_rst,
    output logic                   cpu_run,
    output logic                   mem_rd_en,
    output logic [MEM_AW-1:0]      mem_rd_addr,
    input  logic [DATA_W-1:0]      mem_rd_data,
    output logic [REG_AW-1:0]      reg_rd_addr,
    input  logic [DATA_W-1:0]      reg_rd_data,
    run_dump_controller_if.master  dump,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic [CYC_W-1:0]       cycle_count
);
    localparam int NREG = 2**REG_AW;
    localparam int RCW  = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_CPU, S_RUN, S_DUMP_MEM, S_DUMP_REG, S_DONE
    } state_t;

    // Memory word sub-phases: issue read, capture data, hold for handshake.
    typedef enum logic [1:0] {P_REQ, P_WAIT, P_HOLD} phase_t;

    state_t              state_q, state_d;
    phase_t              ph_q;
    logic [RCW-1:0]      rst_cnt_q;
    logic [CYC_W-1:0]    cyc_q, to_q;
    logic                tmo_q;
    logic [MEM_AW-1:0]   base_q, addr_q;
    logic [MEM_AW:0]     words_q, k_q;
    logic [NREG-1:0]     mask_q, above;
    logic [REG_AW-1:0]   ridx_q;
    logic                ov_q, oreg_q, olast_q;
    logic [DATA_W-1:0]   odata_q;
    logic [MEM_AW-1:0]   oaddr_q;

    logic tmo_hit, run_exit, hs, mem_final, reg_final, regs_any;

    assign tmo_hit   = (to_q != '0) && (cyc_q == to_q - CYC_W'(1));
    assign run_exit  = halt || tmo_hit;
    assign hs        = ov_q && dump.out_ready;
    assign mem_final = (k_q == words_q - (MEM_AW+1)'(1));
    assign regs_any  = |mask_q;
    // Current register is the last one if no selected index lies above it.
    assign above     = mask_q >> ridx_q;
    assign reg_final = ~|above[NREG-1:1];

    assign mem_rd_addr     = addr_q;
    assign reg_rd_addr     = ridx_q;
    assign cycle_count     = cyc_q;
    assign timed_out       = tmo_q;
    assign dump.out_valid  = ov_q;
    assign dump.out_data   = odata_q;
    assign dump.out_is_reg = oreg_q;
    assign dump.out_addr   = oaddr_q;
    assign dump.out_last   = olast_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and CPU/memory control decode.
    always_comb begin
        state_d   = state_q;
        cpu_rst   = 1'b1;
        cpu_run   = 1'b0;
        mem_rd_en = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                done = (state_q == S_DONE);
                if (start) state_d = S_RST_CPU;
            end
            S_RST_CPU: begin
                if (rst_cnt_q == RCW'(RST_CYCLES - 1)) state_d = S_RUN;
            end
            S_RUN: begin
                cpu_rst = 1'b0;
                cpu_run = 1'b1;
                if (run_exit) begin
                    if (words_q != '0)  state_d = S_DUMP_MEM;
                    else if (regs_any)  state_d = S_DUMP_REG;
                    else                state_d = S_DONE;
                end
            end
            S_DUMP_MEM: begin
                cpu_rst   = 1'b0;
                mem_rd_en = (ph_q == P_REQ);
                if (hs && mem_final) state_d = regs_any ? S_DUMP_REG : S_DONE;
            end
            S_DUMP_REG: begin
                cpu_rst = 1'b0;
                if (hs && reg_final) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Config latch, cycle counting and dump datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q      <= P_REQ;
            rst_cnt_q <= '0;
            cyc_q     <= '0;
            to_q      <= '0;
            tmo_q     <= 1'b0;
            base_q    <= '0;
            addr_q    <= '0;
            words_q   <= '0;
            k_q       <= '0;
            mask_q    <= '0;
            ridx_q    <= '0;
            ov_q      <= 1'b0;
            oreg_q    <= 1'b0;
            olast_q   <= 1'b0;
            odata_q   <= '0;
            oaddr_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        to_q      <= timeout_cycles;
                        base_q    <= mem_base;
                        words_q   <= mem_words;
                        mask_q    <= reg_mask;
                        cyc_q     <= '0;
                        tmo_q     <= 1'b0;
                        rst_cnt_q <= '0;
                        ridx_q    <= '0;
                    end
                end
                S_RST_CPU: rst_cnt_q <= rst_cnt_q + RCW'(1);
                S_RUN: begin
                    if (cyc_q != '1) cyc_q <= cyc_q + CYC_W'(1);
                    if (run_exit) begin
                        tmo_q  <= !halt && tmo_hit;
                        k_q    <= '0;
                        addr_q <= base_q;
                        ridx_q <= '0;
                        ph_q   <= P_REQ;
                    end
                end
                S_DUMP_MEM: begin
                    case (ph_q)
                        P_REQ:  ph_q <= P_WAIT;
                        P_WAIT: begin
                            ov_q    <= 1'b1;
                            odata_q <= mem_rd_data;
                            oreg_q  <= 1'b0;
                            oaddr_q <= addr_q;
                            olast_q <= mem_final && !regs_any;
                            ph_q    <= P_HOLD;
                        end
                        default: begin
                            if (dump.out_ready) begin
                                ov_q    <= 1'b0;
                                olast_q <= 1'b0;
                                k_q     <= k_q + (MEM_AW+1)'(1);
                                addr_q  <= addr_q + MEM_AW'(1);
                                ph_q    <= P_REQ;
                            end
                        end
                    endcase
                end
                S_DUMP_REG: begin
                    if (!ov_q) begin
                        if (mask_q[ridx_q]) begin
                            ov_q    <= 1'b1;
                            odata_q <= reg_rd_data;
                            oreg_q  <= 1'b1;
                            oaddr_q <= MEM_AW'(ridx_q);
                            olast_q <= reg_final;
                        end else begin
                            ridx_q <= ridx_q + REG_AW'(1);
                        end
                    end else if (dump.out_ready) begin
                        ov_q    <= 1'b0;
                        olast_q <= 1'b0;
                        ridx_q  <= ridx_q + REG_AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_run_dump_controller.sv
// Bench for run_dump_controller with a behavioural CPU, register file and
// synchronous data memory; dump words are checked against a scoreboard.
module tb_run_dump_controller;
    typedef struct packed {
        logic        is_reg;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, halt;
    logic [23:0] timeout_cycles;
    logic [9:0]  mem_base;
    logic [10:0] mem_words;
    logic [31:0] reg_mask;
    logic        cpu_rst, cpu_run, mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        busy, done, timed_out;
    logic [23:0] cycle_count;

    run_dump_controller_if #(.DATA_W(32), .MEM_AW(10)) dif ();

    run_dump_controller #(
        .DATA_W(32), .MEM_AW(10), .REG_AW(5), .CYC_W(24), .RST_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .timeout_cycles(timeout_cycles),
        .mem_base(mem_base), .mem_words(mem_words), .reg_mask(reg_mask),
        .halt(halt), .cpu_rst(cpu_rst), .cpu_run(cpu_run),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data), .dump(dif), .busy(busy), .done(done),
        .timed_out(timed_out), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Behavioural CPU: pc counts run cycles, r1 mirrors it; halts at halt_at.
    logic [31:0] mem [0:1023];
    logic [31:0] regs [0:31];
    logic [23:0] pc, halt_at;
    logic [31:0] r1;
    logic        halt_en;

    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            pc <= '0;
            r1 <= '0;
        end else if (cpu_run) begin
            pc <= pc + 24'd1;
            r1 <= 32'(pc) + 32'd1;
        end
    end
    assign halt        = halt_en && (pc == halt_at);
    assign reg_rd_data = (reg_rd_addr == 5'd1) ? r1 : regs[reg_rd_addr];

    // Synchronous-read data memory.
    always_ff @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    exp_t  sb[$];
    int    nchk = 0, nerr = 0;
    int    cyc_n = 0, run_cnt = 0, valid_seen = 0;
    int    rdy_mode = 0;
    logic  pv = 1'b0, phs = 1'b0;
    exp_t  pfld;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, drive ready, score handshakes.
    task automatic tick();
        exp_t cur, e;
        logic r, h;
        @(negedge clk);
        cyc_n++;
        if (cpu_rst && busy) run_cnt = 0;
        else if (cpu_run)    run_cnt++;
        if (dif.out_valid) valid_seen++;
        cur = '{dif.out_is_reg, dif.out_addr, dif.out_data, dif.out_last};
        if (pv && !phs) chk("stall_hold", {19'd0, dif.out_valid, cur}, {19'd0, 1'b1, pfld});
        case (rdy_mode)
            0:       r = 1'b1;
            1:       r = (cyc_n % 3 == 0);
            default: r = 1'b0;
        endcase
        dif.out_ready = r;
        h = dif.out_valid && r;
        if (h) begin
            if (sb.size() == 0) chk("extra_word", 64'(cur), 64'd0);
            else begin
                e = sb.pop_front();
                chk("word", 64'(cur), 64'(e));
            end
        end
        pv = dif.out_valid;
        phs = h;
        pfld = cur;
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) break;
        end
        chk("reach_done", 64'(done), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_start(input logic [23:0] to, input logic [9:0] base,
                            input logic [10:0] n, input logic [31:0] mask);
        timeout_cycles = to;
        mem_base  = base;
        mem_words = n;
        reg_mask  = mask;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_mem(input logic [9:0] base, input int n, input logic regs_follow);
        logic [9:0] a;
        for (int k = 0; k < n; k++) begin
            a = base + 10'(k);
            sb.push_back('{1'b0, a, mem[a], (k == n - 1) && !regs_follow});
        end
    endtask

    task automatic push_regs(input logic [31:0] mask, input logic [31:0] r1_exp);
        int hi;
        hi = -1;
        for (int i = 0; i < 32; i++) if (mask[i]) hi = i;
        for (int i = 0; i < 32; i++)
            if (mask[i]) sb.push_back('{1'b1, 10'(i), (i == 1) ? r1_exp : regs[i], i == hi});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(i) * 5;
        mem[0] = 32'd3;
        mem[1] = 32'd2;
        for (int i = 0; i < 32; i++) regs[i] = 32'd100 + 32'(i) * 3;
        regs[19] = 32'd35;
        halt_en = 1'b0; halt_at = '0;
        rst = 1'b1; start = 1'b0; dif.out_ready = 1'b0;
        timeout_cycles = '0; mem_base = '0; mem_words = '0; reg_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", {52'd0, cpu_rst, cpu_run, mem_rd_en, dif.out_valid, dif.out_last,
                          busy, done, timed_out, 4'd0},
            {52'd0, 8'b1000_0000, 4'd0});
        chk("rst_count", {24'd0, cycle_count, 6'd0, reg_rd_addr, mem_rd_addr}, 64'd0);
        rst = 1'b0;

        // AP program result dump.
        halt_en = 1'b1; halt_at = 24'd5; rdy_mode = 0;
        push_mem(10'd0, 2, 1'b1);
        push_regs(32'h1 << 19, 32'd0);
        do_start(24'd0, 10'd0, 11'd2, 32'h1 << 19);
        run_to_done(200);
        chk("ap_timed_out", 64'(timed_out), 64'd0);
        chk("ap_cycles", 64'(cycle_count), 64'd6);
        chk("ap_run_cnt", 64'(run_cnt), 64'd6);

        // Never halts: budget of 100 cycles, r1 must read back frozen at 100.
        halt_en = 1'b0;
        push_regs(32'h12, 32'd100);
        do_start(24'd100, 10'd0, 11'd0, 32'h12);
        run_to_done(400);
        chk("to_cycles", 64'(cycle_count), 64'd100);
        chk("to_timed_out", 64'(timed_out), 64'd1);
        chk("to_run_cnt", 64'(run_cnt), 64'd100);

        // Ten memory words with a sink that accepts one cycle in three.
        halt_en = 1'b1; halt_at = 24'd3; rdy_mode = 1;
        push_mem(10'd20, 10, 1'b0);
        do_start(24'd0, 10'd20, 11'd10, 32'd0);
        run_to_done(400);
        chk("stall_cycles", 64'(cycle_count), 64'd4);

        // Empty dump goes straight to DONE.
        halt_at = 24'd2; rdy_mode = 0; valid_seen = 0;
        do_start(24'd0, 10'd0, 11'd0, 32'd0);
        run_to_done(100);
        chk("empty_no_valid", 64'(valid_seen), 64'd0);
        chk("empty_cycles", 64'(cycle_count), 64'd3);

        // Address wrap; halt and timeout in the same cycle: halt wins.
        halt_at = 24'd9;
        push_mem(10'd1022, 4, 1'b0);
        do_start(24'd10, 10'd1022, 11'd4, 32'd0);
        run_to_done(200);
        chk("tie_timed_out", 64'(timed_out), 64'd0);
        chk("tie_cycles", 64'(cycle_count), 64'd10);

        // Reset while a memory word is stalled on the port.
        halt_at = 24'd2; rdy_mode = 2;
        do_start(24'd0, 10'd5, 11'd3, 32'd0);
        for (int i = 0; i < 100 && !dif.out_valid; i++) tick();
        chk("rst_mid_valid_seen", 64'(dif.out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", {60'd0, dif.out_valid, cpu_rst, busy, mem_rd_en}, {60'd0, 4'b0100});
        rst = 1'b0;
        pv = 1'b0;
        sb.delete();

        // Fresh run; a start pulse during RUN with a different config is ignored.
        halt_at = 24'd20; rdy_mode = 0;
        push_mem(10'd0, 2, 1'b1);
        push_regs(32'h1 << 19, 32'd0);
        do_start(24'd0, 10'd0, 11'd2, 32'h1 << 19);
        for (int i = 0; i < 20 && !cpu_run; i++) tick();
        chk("rerun_running", 64'(cpu_run), 64'd1);
        do_start(24'd3, 10'd7, 11'd0, 32'd0);
        run_to_done(200);
        chk("rerun_cycles", 64'(cycle_count), 64'd21);
        chk("rerun_timed_out", 64'(timed_out), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
